config_rx: RTL and testbench
============================

# config_rx

Serial configuration receiver: the far-end partner of the config transmitter. Runs on the 48 MHz system clock, oversamples the TX_CLK/TX_DAT/TX_OE link (nominal 2.5 MHz bit rate), deserialises C_NO_CFG_BITS-bit words MSB-first and writes each complete word into a local register file through a single-cycle write strobe. Reports frame completion and framing errors to the local controller.

## Interface
- C_NO_CFG_BITS, 24: bits per word on the link; must be ≥ C_ADDR_BITS + C_DATA_BITS.
- C_ADDR_BITS, 3: register address width; the address field is word bits [C_DATA_BITS+C_ADDR_BITS-1 : C_DATA_BITS].
- C_DATA_BITS, 16: register data width; the data field is word bits [C_DATA_BITS-1:0].
- TIMEOUT_CYCLES, 1024: CLOCK cycles without an RX_CLK rising edge, while a frame is active, before the frame is aborted.
- CLOCK  in  1  system clock, 48 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- RX_CLK  in  1  link bit clock; asynchronous to CLOCK; data is valid on its rising edge.
- RX_DAT  in  1  link serial data, MSB first.
- RX_OE  in  1  link frame enable, active high; high for the whole frame.
- WR_EN  out  1  one-cycle write strobe.
- WR_ADDR  out  C_ADDR_BITS  register address, valid with WR_EN.
- WR_DATA  out  C_DATA_BITS  register data, valid with WR_EN.
- RX_END  out  1  one-cycle pulse: frame closed cleanly with ≥1 word.
- RX_ERR  out  1  one-cycle pulse: frame aborted.
- WORD_CNT  out  8  words written in the most recent frame; held until the next frame starts.

## Operation
- RX_CLK, RX_DAT and RX_OE each pass through a 2-flop synchroniser plus one history flop. Edges are detected on the synchronised copies. All three share identical delay, so data alignment to the clock edge is preserved.
- States: IDLE, SHIFT, WRITE, ERROR.
- IDLE: wait for an RX_OE rising edge. On that edge: clear the bit counter, the timeout counter and WORD_CNT, then go to SHIFT. An RX_OE that is already high when reset deasserts is ignored until it falls and rises again.
- SHIFT: on each synchronised RX_CLK rising edge, shift RX_DAT into the LSB of the shift register, increment the bit counter and clear the timeout counter.
  - When the bit counter reaches C_NO_CFG_BITS, go to WRITE.
  - On an RX_OE falling edge with bit counter = 0: if WORD_CNT > 0, pulse RX_END and go to IDLE; otherwise go to IDLE silently.
  - On an RX_OE falling edge with bit counter ≠ 0: discard the partial word and go to ERROR.
  - When the timeout counter reaches TIMEOUT_CYCLES: go to ERROR.
- WRITE (one cycle): assert WR_EN with the address and data fields, increment WORD_CNT (saturates at 255), clear the bit counter, return to SHIFT. Bits of the word above the address field are ignored.
- ERROR (one cycle): pulse RX_ERR, then go to IDLE. Words already written in the frame stay written; WORD_CNT holds their count.
- RX_CLK edges while in IDLE or ERROR are ignored.
- An RX_OE fall detected in the same cycle as the final bit edge: the final bit completes the word, WRITE occurs, and the fall is then handled in SHIFT with bit counter = 0, giving a clean end.

## Timing
- Reset values: WR_EN=0, WR_ADDR=0, WR_DATA=0, RX_END=0, RX_ERR=0, WORD_CNT=0, state IDLE, all synchroniser flops 0.
- RX_CLK high and low phases must each be ≥ 3 CLOCK cycles; the nominal 2.5 MHz clock gives about 9.6 cycles per phase.
- Latency from the pin-level RX_CLK rising edge of the last bit to WR_EN high: 4 CLOCK cycles (2 synchroniser + 1 edge/shift + 1 WRITE register).
- RX_END or RX_ERR rises 4 CLOCK cycles after the pin-level RX_OE fall.
- WR_ADDR and WR_DATA hold their values after WR_EN until the next write.
- Reset asserted mid-frame: all state clears immediately and no write is issued.

## Configuration
- CONFIG_RX_PARITY_EN defined:
  - Each word carries C_NO_CFG_BITS+1 bits; the final bit is even parity over the preceding C_NO_CFG_BITS bits.
  - On a parity mismatch, WRITE is suppressed, RX_ERR pulses and the frame continues in SHIFT; WORD_CNT does not increment.
- CONFIG_RX_PARITY_EN undefined: words are exactly C_NO_CFG_BITS bits and no parity check is performed.

## Structure
- Package config_rx_pkg: the state enumeration, the default width constants and the word-length constant (C_NO_CFG_BITS, plus one when parity is enabled).
- Sub-module cfg_sync_edge: 2-flop synchroniser plus history flop, with rise and fall outputs. Instantiated three times, for RX_CLK, RX_DAT and RX_OE.

## Test plan
- Two-word frame at 2.5 MHz: words 0x01A5A5 and 0x025A5A → WR_EN pulses with (1, 0xA5A5) then (2, 0x5A5A); RX_END pulses once; WORD_CNT=2.
- RX_OE falls after 10 bits of the second word → exactly one write; RX_ERR pulses; no RX_END; WORD_CNT=1.
- RX_OE held high and RX_CLK stopped after 5 bits → RX_ERR pulses 1024 cycles after the last edge; no write.
- RX_OE high at reset release, then 24 clocks sent → no write until RX_OE toggles low then high.
- RESET_N asserted at bit 12 → outputs zero at once; the next full frame writes correctly.
- CONFIG_RX_PARITY_EN: word 0x030001 sent with a wrong parity bit → no write; RX_ERR pulses; a following good word is written; RX_END pulses with WORD_CNT=1.

Source files
------------

// File: rtl/config_rx_pkg.sv
// Shared types and constants for the serial configuration receiver.
// Optional feature macro: CONFIG_RX_PARITY_EN (adds one even-parity bit per word).
package config_rx_pkg;

    localparam int C_NO_CFG_BITS_DEF  = 24;
    localparam int C_ADDR_BITS_DEF    = 3;
    localparam int C_DATA_BITS_DEF    = 16;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

`ifdef CONFIG_RX_PARITY_EN
    localparam int C_PAR_BITS = 1;
`else
    localparam int C_PAR_BITS = 0;
`endif

    localparam int C_WORD_BITS = C_NO_CFG_BITS_DEF + C_PAR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2,
        ST_ERROR = 2'd3
    } rx_state_t;

endpackage

// File: rtl/config_rx_if.sv
// Link-side inputs and register-file write port of the configuration receiver.
// Optional feature macro: CONFIG_RX_PARITY_EN (no effect on this interface).
interface config_rx_if import config_rx_pkg::*; #(
    parameter int C_ADDR_BITS = C_ADDR_BITS_DEF,
    parameter int C_DATA_BITS = C_DATA_BITS_DEF
);
    logic                   rx_clk;
    logic                   rx_dat;
    logic                   rx_oe;
    logic                   wr_en;
    logic [C_ADDR_BITS-1:0] wr_addr;
    logic [C_DATA_BITS-1:0] wr_data;
    logic                   rx_end;
    logic                   rx_err;
    logic [7:0]             word_cnt;

    modport master (
        output rx_clk, rx_dat, rx_oe,
        input  wr_en, wr_addr, wr_data, rx_end, rx_err, word_cnt
    );

    modport slave (
        input  rx_clk, rx_dat, rx_oe,
        output wr_en, wr_addr, wr_data, rx_end, rx_err, word_cnt
    );
endinterface

// File: rtl/config_rx_sync_edge.sv
// Two-flop synchroniser plus history flop with rise/fall detection.
// Optional feature macro: CONFIG_RX_PARITY_EN (no effect on this module).
module cfg_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta_q, sync_q, hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;
    assign fall  = ~sync_q & hist_q;
endmodule

// File: rtl/config_rx.sv
// Serial configuration receiver: oversamples the link, deserialises words MSB-first, writes them out.
// Optional feature macro: CONFIG_RX_PARITY_EN (trailing even-parity bit, bad words dropped with RX_ERR).
//
// state    | meaning
// ST_IDLE  | waiting for an armed RX_OE rising edge
// ST_SHIFT | collecting bits on RX_CLK rises, watching RX_OE and the timeout
// ST_WRITE | one cycle: issue the write strobe (or flag a parity error)
// ST_ERROR | one cycle: pulse RX_ERR, then back to idle
module config_rx import config_rx_pkg::*; #(
    parameter int C_NO_CFG_BITS  = C_NO_CFG_BITS_DEF,
    parameter int C_ADDR_BITS    = C_ADDR_BITS_DEF,
    parameter int C_DATA_BITS    = C_DATA_BITS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    config_rx_if.slave  bus
);
    localparam int W  = C_NO_CFG_BITS + C_PAR_BITS;
    localparam int BW = $clog2(W + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_rise, clk_lvl_unused, clk_fall_unused;
    logic dat_lvl, dat_rise_unused, dat_fall_unused;
    logic oe_lvl, oe_rise, oe_fall_unused;

    cfg_sync_edge u_sync_clk (.clk(clk), .rst_n(rst_n), .async_in(bus.rx_clk),
                              .level(clk_lvl_unused), .rise(clk_rise), .fall(clk_fall_unused));
    cfg_sync_edge u_sync_dat (.clk(clk), .rst_n(rst_n), .async_in(bus.rx_dat),
                              .level(dat_lvl), .rise(dat_rise_unused), .fall(dat_fall_unused));
    cfg_sync_edge u_sync_oe  (.clk(clk), .rst_n(rst_n), .async_in(bus.rx_oe),
                              .level(oe_lvl), .rise(oe_rise), .fall(oe_fall_unused));

    rx_state_t              state_q;
    logic [W-1:0]           shift_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [TW-1:0]          to_cnt_q;
    logic [7:0]             word_cnt_q;
    logic                   wr_en_q, rx_end_q, rx_err_q, end_pend_q;
    logic [C_ADDR_BITS-1:0] wr_addr_q;
    logic [C_DATA_BITS-1:0] wr_data_q;
    logic [1:0]             settle_q;
    logic                   armed_q;
    logic                   par_bad;
    logic                   shift_hi_unused;

`ifdef CONFIG_RX_PARITY_EN
    assign par_bad = ^shift_q;
`else
    assign par_bad = 1'b0;
`endif
    assign shift_hi_unused = ^shift_q;

    // A frame may only start once RX_OE has been seen low after the synchroniser settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            word_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rx_end_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            end_pend_q <= 1'b0;
            settle_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            wr_en_q    <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_end_q   <= end_pend_q;
            end_pend_q <= 1'b0;
            if (settle_q != 2'd3)
                settle_q <= settle_q + 2'd1;
            else if (!oe_lvl)
                armed_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (oe_rise && armed_q) begin
                        bit_cnt_q  <= '0;
                        to_cnt_q   <= TW'(TIMEOUT_CYCLES);
                        word_cnt_q <= '0;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        shift_q   <= {shift_q[W-2:0], dat_lvl};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        to_cnt_q  <= TW'(TIMEOUT_CYCLES);
                        if (bit_cnt_q == BW'(W - 1))
                            state_q <= ST_WRITE;
                    end else if (!oe_lvl) begin
                        // Level test so a fall coinciding with the last bit is honoured after WRITE.
                        if (bit_cnt_q == '0) begin
                            end_pend_q <= (word_cnt_q != 8'd0);
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_ERROR;
                        end
                    end else if (to_cnt_q == '0) begin
                        state_q <= ST_ERROR;
                    end else begin
                        to_cnt_q <= to_cnt_q - 1'b1;
                    end
                end
                ST_WRITE: begin
                    bit_cnt_q <= '0;
                    state_q   <= ST_SHIFT;
                    if (par_bad) begin
                        rx_err_q <= 1'b1;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= shift_q[C_PAR_BITS + C_DATA_BITS +: C_ADDR_BITS];
                        wr_data_q <= shift_q[C_PAR_BITS +: C_DATA_BITS];
                        if (word_cnt_q != 8'hFF)
                            word_cnt_q <= word_cnt_q + 8'd1;
                    end
                end
                ST_ERROR: begin
                    rx_err_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rx_end   = rx_end_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.word_cnt = word_cnt_q;
endmodule

// File: tb/tb_config_rx.sv
// Bench for config_rx: directed and randomized frames against a word-level expectation queue.
// Optional feature macro: CONFIG_RX_PARITY_EN (enables the parity frame case).
module tb_config_rx;
    import config_rx_pkg::*;

    localparam int T = TIMEOUT_CYCLES_DEF;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    config_rx_if bus ();
    config_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int  n_pass = 0;
    int  n_fail = 0;
    int  n_total = 0;
    int  n_end = 0;
    int  n_err = 0;
    wr_t got_q[$];
    wr_t exp_q[$];

    always @(negedge clk) begin
        wr_t w;
        if (bus.wr_en) begin
            w.a = bus.wr_addr;
            w.d = bus.wr_data;
            got_q.push_back(w);
        end
        if (bus.rx_end) n_end++;
        if (bus.rx_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.rx_dat = b;
        clocks(5);
        bus.rx_clk = 1'b1;
        clocks(10);
        bus.rx_clk = 1'b0;
        clocks(5);
    endtask

    // Sends the first nbits of the link word (data word plus parity bit when enabled).
    task automatic send_word(input logic [23:0] w, input int nbits, input logic bad_par);
        logic [C_WORD_BITS-1:0] fw;
`ifdef CONFIG_RX_PARITY_EN
        fw = {w, (^w) ^ bad_par};
`else
        fw = w;
        if (bad_par) fw = w;
`endif
        for (int i = 0; i < nbits; i++) send_bit(fw[C_WORD_BITS-1-i]);
    endtask

    task automatic frame_open();
        bus.rx_oe = 1'b1;
        clocks(20);
    endtask

    task automatic frame_close();
        clocks(10);
        bus.rx_oe = 1'b0;
        clocks(30);
    endtask

    task automatic begin_scn();
        got_q.delete();
        exp_q.delete();
        n_end = 0;
        n_err = 0;
    endtask

    task automatic expect_word(input logic [23:0] w);
        wr_t e;
        e.a = 3'((w >> 16) & 24'h7);
        e.d = 16'(w & 24'hFFFF);
        exp_q.push_back(e);
    endtask

    task automatic finish_scn(input string tag, input int e_end, input int e_err, input int e_wc);
        check({tag, ".n_writes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), {29'd0, got_q[i].a}, {29'd0, exp_q[i].a});
            check($sformatf("%s.data%0d", tag, i), {16'd0, got_q[i].d}, {16'd0, exp_q[i].d});
        end
        check({tag, ".rx_end"}, n_end, e_end);
        check({tag, ".rx_err"}, n_err, e_err);
        check({tag, ".word_cnt"}, {24'd0, bus.word_cnt}, e_wc);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".wr_en"}, {31'd0, bus.wr_en}, 0);
        check({tag, ".wr_addr"}, {29'd0, bus.wr_addr}, 0);
        check({tag, ".wr_data"}, {16'd0, bus.wr_data}, 0);
        check({tag, ".rx_end"}, {31'd0, bus.rx_end}, 0);
        check({tag, ".rx_err"}, {31'd0, bus.rx_err}, 0);
        check({tag, ".word_cnt"}, {24'd0, bus.word_cnt}, 0);
    endtask

    initial begin
        logic [23:0] w;
        int          nw, cyc, nbits;
        logic        abort;

        bus.rx_clk = 1'b0;
        bus.rx_dat = 1'b0;
        bus.rx_oe  = 1'b0;
        clocks(3);
        check_zero("reset");
        rst_n = 1'b1;
        clocks(10);

        // Two-word frame with the reference words
        begin_scn();
        frame_open();
        send_word(24'h01A5A5, C_WORD_BITS, 1'b0); expect_word(24'h01A5A5);
        send_word(24'h025A5A, C_WORD_BITS, 1'b0); expect_word(24'h025A5A);
        frame_close();
        finish_scn("two_word", 1, 0, 2);

        // RX_OE drops ten bits into the second word
        begin_scn();
        w = 24'($urandom);
        frame_open();
        send_word(w, C_WORD_BITS, 1'b0); expect_word(w);
        send_word(24'($urandom), 10, 1'b0);
        frame_close();
        finish_scn("abort", 0, 1, 1);

        // RX_CLK stops after five bits with RX_OE still high
        begin_scn();
        frame_open();
        send_word(24'($urandom), 4, 1'b0);
        bus.rx_dat = 1'b1;
        clocks(5);
        bus.rx_clk = 1'b1;
        cyc = 0;
        while (!bus.rx_err && cyc < T + 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) bus.rx_clk = 1'b0;
        end
        check("timeout.window", {31'd0, (cyc >= T && cyc <= T + 8)}, 1);
        frame_close();
        finish_scn("timeout", 0, 1, 0);

        // RX_OE already high when reset is released
        rst_n = 1'b0;
        bus.rx_oe = 1'b1;
        clocks(3);
        rst_n = 1'b1;
        begin_scn();
        clocks(20);
        send_word(24'($urandom), C_WORD_BITS, 1'b0);
        clocks(20);
        check("oe_at_reset.no_write", got_q.size(), 0);
        bus.rx_oe = 1'b0;
        clocks(20);
        w = 24'($urandom);
        frame_open();
        send_word(w, C_WORD_BITS, 1'b0); expect_word(w);
        frame_close();
        finish_scn("oe_at_reset", 1, 0, 1);

        // Reset in the middle of the second word
        begin_scn();
        w = 24'($urandom) | 24'h010000;
        frame_open();
        send_word(w, C_WORD_BITS, 1'b0);
        send_word(24'($urandom), 12, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        bus.rx_oe  = 1'b0;
        bus.rx_clk = 1'b0;
        clocks(3);
        check("mid_reset.writes", got_q.size(), 1);
        rst_n = 1'b1;
        clocks(10);
        begin_scn();
        frame_open();
        for (int i = 0; i < 3; i++) begin
            w = 24'($urandom);
            send_word(w, C_WORD_BITS, 1'b0); expect_word(w);
        end
        frame_close();
        finish_scn("after_reset", 1, 0, 3);

        // Randomized frames, some ending in a partial word
        for (int f = 0; f < 4; f++) begin
            begin_scn();
            nw    = $urandom_range(1, 3);
            abort = 1'($urandom_range(0, 1));
            frame_open();
            for (int i = 0; i < nw; i++) begin
                w = 24'($urandom);
                send_word(w, C_WORD_BITS, 1'b0); expect_word(w);
            end
            if (abort) begin
                nbits = $urandom_range(1, C_WORD_BITS - 1);
                send_word(24'($urandom), nbits, 1'b0);
            end
            frame_close();
            finish_scn($sformatf("rand%0d", f), abort ? 0 : 1, abort ? 1 : 0, nw);
        end

`ifdef CONFIG_RX_PARITY_EN
        // Bad parity word is dropped, the frame carries on
        begin_scn();
        w = 24'($urandom);
        frame_open();
        send_word(24'h030001, C_WORD_BITS, 1'b1);
        send_word(w, C_WORD_BITS, 1'b0); expect_word(w);
        frame_close();
        finish_scn("parity", 1, 1, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
